m_shiftunit: RTL and testbench



---
 rtl/m_shift_pkg.sv | 19 +
 rtl/m_shiftstep.sv | 29 ++
 rtl/m_shiftunit.sv | 116 +++++++++++
 tb/tb_m_shiftunit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/m_shift_pkg.sv
// Shared encodings for the midgetv iterative shift engine.
package m_shift_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_RSV = 2'b10,
    SH_SRA = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_st_e;

endpackage

// File: rtl/m_shiftstep.sv
// Combinational single step of the shift engine: one position, or eight when byte_sel is set.
module m_shiftstep
  import m_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] sreg_i,
  input  sh_op_e           kind_i,
  input  logic             byte_sel_i,
  output logic [WIDTH-1:0] sreg_o
);

  logic fill;

  // Reserved encoding falls through to the logical right shift.
  assign fill = (kind_i == SH_SRA) & sreg_i[WIDTH-1];

  always_comb begin
    sreg_o = sreg_i;
    if (kind_i == SH_SLL) begin
      if (byte_sel_i) sreg_o = {sreg_i[WIDTH-9:0], 8'h00};
      else            sreg_o = {sreg_i[WIDTH-2:0], 1'b0};
    end else begin
      if (byte_sel_i) sreg_o = {{8{fill}}, sreg_i[WIDTH-1:8]};
      else            sreg_o = {fill, sreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/m_shiftunit.sv
// Iterative 32-bit shift engine: one shift step per clock, done pulse on completion.
// Define M_SHIFTUNIT_BYTESTEP_EN to shift by 8 while the remaining count is >= 8.
module m_shiftunit
  import m_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               lastshift,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  sh_st_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  sh_op_e             kind_q, kind_d;
  logic [WIDTH-1:0]   step_out;
  logic               byte_sel;
  logic [SHAMT_W-1:0] dec;

`ifdef M_SHIFTUNIT_BYTESTEP_EN
  assign byte_sel = (cnt_q >= 5'd8);
`else
  assign byte_sel = 1'b0;
`endif

  assign dec = byte_sel ? 5'd8 : 5'd1;

  m_shiftstep #(.WIDTH(WIDTH)) u_step (
    .sreg_i     (sreg_q),
    .kind_i     (kind_q),
    .byte_sel_i (byte_sel),
    .sreg_o     (step_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: done/busy come only from registered state.
  always_comb begin
    busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    done      = (state_q == ST_DONE);
    lastshift = 1'b0;
    if (state_q == ST_SHIFT) begin
`ifdef M_SHIFTUNIT_BYTESTEP_EN
      lastshift = (cnt_q == 5'd1) || (cnt_q == 5'd8);
`else
      lastshift = (cnt_q == 5'd1);
`endif
    end
  end

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    dout_d = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sreg_d = din;
          cnt_d  = shamt;
          kind_d = sh_op_e'(op);
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d = step_out;
          cnt_d  = cnt_q - dec;
        end else begin
          dout_d = sreg_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      kind_q <= SH_SLL;
      dout_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_m_shiftunit.sv
// Scoreboard bench for m_shiftunit: driver pushes expectations, monitor checks on done.
module tb_m_shiftunit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic        busy, lastshift, done;
  logic [31:0] dout;

  typedef struct {
    logic [31:0] exp_dout;
    int          steps;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   ls_cnt = 0;
  int   ls_cyc = 0;

  m_shiftunit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .din       (din),
    .shamt     (shamt),
    .busy      (busy),
    .lastshift (lastshift),
    .done      (done),
    .dout      (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int steps_of(input int n);
`ifdef M_SHIFTUNIT_BYTESTEP_EN
    return n / 8 + n % 8;
`else
    return n;
`endif
  endfunction

  // Monitor: count lastshift pulses and compare each done against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      ls_cnt = 0;
    end else begin
      if (lastshift) begin
        ls_cnt++;
        ls_cyc = cyc;
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with dout %h, expected no done", dout);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_dout"}, dout, e.exp_dout);
          check({e.name, "_latency"}, cyc - e.t0, e.steps + 2);
          check({e.name, "_busy_with_done"}, {31'd0, busy}, 32'd1);
          check({e.name, "_lastshift_count"}, ls_cnt, (e.steps > 0) ? 1 : 0);
          if (e.steps > 0)
            check({e.name, "_lastshift_cycle"}, ls_cyc - e.t0, e.steps);
        end
        ls_cnt = 0;
      end
    end
  end

  // Drives start for one cycle; checks busy rises in the following cycle.
  task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] s, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    e.exp_dout = exp;
    e.steps    = steps_of(int'(s));
    e.t0       = cyc;
    e.name     = nm;
    sb.push_back(e);
    start = 1'b1; op = o; din = d; shamt = s;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_rise"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done", nm, k);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; din = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_lastshift", {31'd0, lastshift}, 32'd0);
    check("rst_dout", dout, 32'h0);
    rst = 1'b0;

    issue("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);   wait_done("sll31");
    issue("sra4",  2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000);   wait_done("sra4");
    issue("srl4",  2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000);   wait_done("srl4");
    issue("rsv4",  2'b10, 32'h8000_0000, 5'd4,  32'h0800_0000);   wait_done("rsv4");
    issue("z_sll", 2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);   wait_done("z_sll");
    issue("z_srl", 2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);   wait_done("z_srl");
    issue("z_sra", 2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);   wait_done("z_sra");
    issue("sll17", 2'b00, 32'h0000_0001, 5'd17, 32'h0002_0000);   wait_done("sll17");
    issue("sll16", 2'b00, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000);   wait_done("sll16");
    issue("sra31", 2'b11, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);   wait_done("sra31");

    // start during busy must be dropped; back-to-back start right after done is taken
    issue("srl8_busy", 2'b01, 32'hF0F0_F0F0, 5'd8, 32'h00F0_F0F0);
    @(negedge clk);
    start = 1'b1; op = 2'b00; din = 32'h1111_1111; shamt = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("srl8_busy");
    issue("b2b_sll4", 2'b00, 32'h1234_5678, 5'd4, 32'h2345_6780); wait_done("b2b_sll4");

    // abort at step 3 of a 10-step shift
    issue("abort10", 2'b01, 32'hFFFF_FFFF, 5'd10, 32'h003F_FFFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dout", dout, 32'h0);
    repeat (40) @(negedge clk);

    issue("post_sra1", 2'b11, 32'h8000_0001, 5'd1, 32'hC000_0000); wait_done("post_sra1");
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
